mem_bus_ctrl: RTL and testbench

//  Synchronous bus controller sitting directly upstream of the level-sensitive RAM block.

---
 rtl/mem_bus_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: single-word CPU-to-RAM bus controller.
// Takes one read or write request at a time over a req/ready handshake and
// drives the level-sensitive RAM through SETUP -> STROBE -> HOLD so that the
// address and data are stable before, during and after every strobe. Every
// output is a register, so the RAM never sees a combinational glitch.
module mem_bus_ctrl #(
    parameter int ADLINES     = 8,
    parameter int DATALINES   = 16,
    parameter int RAMSIZE     = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [ADLINES-1:0]   cpu_addr,
    input  logic [DATALINES-1:0] cpu_wdata,
    output logic                 cpu_ready,
    output logic                 cpu_done,
    output logic                 cpu_err,
    output logic [DATALINES-1:0] cpu_rdata,
    output logic [ADLINES-1:0]   ram_addr,
    output logic [DATALINES-1:0] ram_wdata,
    output logic                 ram_read,
    output logic                 ram_write,
    input  logic [DATALINES-1:0] ram_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        RESP
    } state_t;

    // Strobe length is WAIT_STATES+1 cycles; the counter runs 0..WAIT_STATES.
    localparam logic [3:0] LAST_WAIT = 4'(WAIT_STATES);

    // One extra bit so that RAMSIZE = 2**ADLINES is representable and the
    // compare stays unsigned over the full address width.
    localparam logic [ADLINES:0] RAM_LIMIT = RAMSIZE[ADLINES:0];

    state_t     state;
    state_t     next_state;
    logic [3:0] wait_cnt;
    logic [3:0] wait_cnt_next;

    logic lat_we;
    logic lat_err;

    logic accept;
    logic in_range;
    logic last_strobe;

    logic ready_next;
    logic done_next;
    logic err_next;
    logic read_next;
    logic write_next;

    assign accept      = (state == IDLE) && cpu_req;
    assign in_range    = ({1'b0, cpu_addr} < RAM_LIMIT);
    assign last_strobe = (state == STROBE) && (wait_cnt == LAST_WAIT);

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Out-of-range requests detour through HOLD (strobes
    // off, address untouched) so that done lands one cycle after accept.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = in_range ? SETUP : HOLD;
                end
            end
            SETUP: begin
                next_state = STROBE;
            end
            STROBE: begin
                if (last_strobe) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                next_state = RESP;
            end
            RESP: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Wait-state counter: advances only inside STROBE, cleared everywhere else.
    always_comb begin
        wait_cnt_next = 4'd0;
        if ((state == STROBE) && !last_strobe) begin
            wait_cnt_next = wait_cnt + 4'd1;
        end
    end

    // Wait-state counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 4'd0;
        end else begin
            wait_cnt <= wait_cnt_next;
        end
    end

    // Request attributes captured at accept and held for the whole access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_we  <= 1'b0;
            lat_err <= 1'b0;
        end else if (accept) begin
            lat_we  <= cpu_we;
            lat_err <= !in_range;
        end
    end

    // Output values for the state being entered, so the registers below
    // change exactly on the edge that enters each state.
    always_comb begin
        ready_next = 1'b0;
        done_next  = 1'b0;
        err_next   = 1'b0;
        read_next  = 1'b0;
        write_next = 1'b0;
        case (next_state)
            IDLE: begin
                ready_next = 1'b1;
            end
            STROBE: begin
                write_next = lat_we;
                read_next  = !lat_we;
            end
            RESP: begin
                done_next = 1'b1;
                err_next  = lat_err;
            end
            default: begin
                ready_next = 1'b0;
            end
        endcase
    end

    // Handshake and strobe output registers; strobes drop asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_ready <= 1'b1;
            cpu_done  <= 1'b0;
            cpu_err   <= 1'b0;
            ram_read  <= 1'b0;
            ram_write <= 1'b0;
        end else begin
            cpu_ready <= ready_next;
            cpu_done  <= done_next;
            cpu_err   <= err_next;
            ram_read  <= read_next;
            ram_write <= write_next;
        end
    end

    // RAM address/data load on entry to SETUP and otherwise keep their value,
    // so they stay put through STROBE, HOLD and the following idle time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else if (accept && in_range) begin
            ram_addr  <= cpu_addr;
            ram_wdata <= cpu_wdata;
        end
    end

    // Read data is captured on the final strobe edge and held until the next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rdata <= '0;
        end else if (last_strobe && !lat_we) begin
            cpu_rdata <= ram_rdata;
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: directed bench for mem_bus_ctrl with a transaction-level
// reference model checked against the main instance on every falling edge.
module tb_mem_bus_ctrl;

    localparam int W  = 1;
    localparam int RS = 256;

    logic        clk;
    logic        rst_n;
    logic        cpu_req;
    logic        cpu_we;
    logic [7:0]  cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ready;
    logic        cpu_done;
    logic        cpu_err;
    logic [15:0] cpu_rdata;
    logic [7:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_read;
    logic        ram_write;
    logic [15:0] ram_rdata;

    logic        req_b;
    logic        we_b;
    logic [7:0]  addr_b;
    logic [15:0] wdata_b;
    logic        ready_b;
    logic        done_b;
    logic        err_b;
    logic [15:0] rdata_b;
    logic [7:0]  ram_addr_b;
    logic [15:0] ram_wdata_b;
    logic        ram_read_b;
    logic        ram_write_b;
    logic [15:0] ram_rdata_b;

    int assert_count = 0;
    int fail_count   = 0;
    int cyc          = 0;

    mem_bus_ctrl #(.ADLINES(8), .DATALINES(16), .RAMSIZE(RS), .WAIT_STATES(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_read(ram_read),
        .ram_write(ram_write), .ram_rdata(ram_rdata)
    );

    mem_bus_ctrl #(.ADLINES(8), .DATALINES(16), .RAMSIZE(16), .WAIT_STATES(W)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(req_b), .cpu_we(we_b), .cpu_addr(addr_b), .cpu_wdata(wdata_b),
        .cpu_ready(ready_b), .cpu_done(done_b), .cpu_err(err_b), .cpu_rdata(rdata_b),
        .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b), .ram_read(ram_read_b),
        .ram_write(ram_write_b), .ram_rdata(ram_rdata_b)
    );

    // Clock generator, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used to measure request spacing.
    always @(posedge clk) cyc <= cyc + 1;

    // Level-sensitive RAM behind the main instance.
    logic [15:0] ram_mem [0:255];
    always @(ram_write or ram_addr or ram_wdata) begin
        if (ram_write) ram_mem[ram_addr] = ram_wdata;
    end
    assign ram_rdata = ram_mem[ram_addr];

    // The small instance always reads back a fixed pattern.
    assign ram_rdata_b = 16'hA5A5;

    // Reference model: an access accepted at edge E0 sits k edges later in
    // phase k; a valid access strobes for phases 1..W+1 and completes in W+3,
    // an out-of-range one completes in phase 1.
    bit          m_busy;
    int          m_k;
    bit          m_we;
    bit          m_err;
    logic [7:0]  m_addr;
    logic [15:0] m_wdata;
    logic [7:0]  e_addr;
    logic [15:0] e_wdata;
    logic [15:0] e_rdata;
    logic [15:0] m_mem [0:255];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_k     <= 0;
            e_addr  <= 8'h00;
            e_wdata <= 16'h0000;
            e_rdata <= 16'h0000;
        end else if (!m_busy) begin
            if (cpu_req) begin
                m_busy  <= 1'b1;
                m_k     <= 0;
                m_we    <= cpu_we;
                m_addr  <= cpu_addr;
                m_wdata <= cpu_wdata;
                m_err   <= (int'(cpu_addr) >= RS);
                if (int'(cpu_addr) < RS) begin
                    e_addr  <= cpu_addr;
                    e_wdata <= cpu_wdata;
                end
            end
        end else begin
            m_k <= m_k + 1;
            if (!m_err && m_we && m_k == 0) m_mem[m_addr] <= m_wdata;
            if (!m_err && !m_we && m_k == W + 1) e_rdata <= m_mem[m_addr];
            if (m_k == (m_err ? 1 : W + 3)) m_busy <= 1'b0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Compare process: main instance against the model on every falling edge.
    always @(negedge clk) begin
        bit x_done;
        bit x_strobe;
        x_done   = m_busy && (m_k == (m_err ? 1 : W + 3));
        x_strobe = m_busy && !m_err && (m_k >= 1) && (m_k <= W + 1);
        checkOutput("m_ready", 32'(cpu_ready), 32'(!m_busy));
        checkOutput("m_done", 32'(cpu_done), 32'(x_done));
        checkOutput("m_err", 32'(cpu_err), 32'(x_done && m_err));
        checkOutput("m_write", 32'(ram_write), 32'(x_strobe && m_we));
        checkOutput("m_read", 32'(ram_read), 32'(x_strobe && !m_we));
        checkOutput("m_ram_addr", 32'(ram_addr), 32'(e_addr));
        checkOutput("m_ram_wdata", 32'(ram_wdata), 32'(e_wdata));
        checkOutput("m_rdata", 32'(cpu_rdata), 32'(e_rdata));
    end

    // Observations of the most recent access.
    int          done_at;
    int          wr_cycles;
    int          rd_cycles;
    int          accept_cyc;
    bit          ready_low;
    logic [15:0] rdata_at_done;
    logic        err_at_done;
    logic [7:0]  addr_log [0:39];

    // Issue one request to the selected instance and record what it does
    // until done (sample j is the falling edge after edge E0+j).
    task automatic applyStimulus(input bit sel, input bit we, input logic [7:0] addr,
                                 input logic [15:0] wdata, input bit keep_req);
        int  n;
        logic dn;
        n = 0;
        while (((sel ? ready_b : cpu_ready) !== 1'b1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checkOutput("ready_timeout", 32'(sel ? ready_b : cpu_ready), 32'd1);
            return;
        end
        if (sel) begin
            req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
        @(posedge clk);
        @(negedge clk);
        accept_cyc = cyc;
        if (!keep_req) begin
            if (sel) req_b = 1'b0;
            else cpu_req = 1'b0;
        end
        done_at = -1; wr_cycles = 0; rd_cycles = 0; ready_low = 1'b1; dn = 1'b0;
        for (int j = 0; j < 40; j++) begin
            addr_log[j] = sel ? ram_addr_b : ram_addr;
            if (sel ? ram_write_b : ram_write) wr_cycles++;
            if (sel ? ram_read_b : ram_read) rd_cycles++;
            if (sel ? ready_b : cpu_ready) ready_low = 1'b0;
            dn = sel ? done_b : cpu_done;
            if (dn) begin
                done_at       = j;
                rdata_at_done = sel ? rdata_b : cpu_rdata;
                err_at_done   = sel ? err_b : cpu_err;
                break;
            end
            @(negedge clk);
        end
        if (done_at < 0) checkOutput("done_timeout", 32'(dn), 32'd1);
    endtask

    // Watchdog.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h05; cpu_wdata = 16'h1234;
        req_b = 1'b0; we_b = 1'b0; addr_b = 8'h00; wdata_b = 16'h0000;

        // Reset with a request held: idle outputs.
        repeat (2) @(negedge clk);
        checkOutput("rst_ready", 32'(cpu_ready), 32'd1);
        checkOutput("rst_done", 32'(cpu_done), 32'd0);
        checkOutput("rst_err", 32'(cpu_err), 32'd0);
        checkOutput("rst_rdata", 32'(cpu_rdata), 32'h0);
        checkOutput("rst_ram_addr", 32'(ram_addr), 32'h0);
        checkOutput("rst_ram_wdata", 32'(ram_wdata), 32'h0);
        checkOutput("rst_ram_read", 32'(ram_read), 32'd0);
        checkOutput("rst_ram_write", 32'(ram_write), 32'd0);
        checkOutput("rst_ready_b", 32'(ready_b), 32'd1);

        // First edge after release accepts the held request.
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("first_accept", 32'(cpu_ready), 32'd0);
        checkOutput("first_ram_addr", 32'(ram_addr), 32'h05);
        cpu_req = 1'b0;
        n = 0;
        while (cpu_done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checkOutput("first_done", 32'(cpu_done), 32'd1);

        // Write 0x10 = 0x000F.
        applyStimulus(1'b0, 1'b1, 8'h10, 16'h000F, 1'b0);
        checkOutput("wr_strobe_len", 32'(wr_cycles), 32'd2);
        checkOutput("wr_no_read", 32'(rd_cycles), 32'd0);
        checkOutput("wr_done_at", 32'(done_at), 32'd4);
        checkOutput("wr_err", 32'(err_at_done), 32'd0);
        checkOutput("wr_addr_setup", 32'(addr_log[0]), 32'h10);
        checkOutput("wr_addr_hold", 32'(addr_log[3]), 32'h10);
        checkOutput("wr_ready_low", 32'(ready_low), 32'd1);

        // Read it back, then confirm the value is held in idle.
        applyStimulus(1'b0, 1'b0, 8'h10, 16'h0000, 1'b0);
        checkOutput("rd_strobe_len", 32'(rd_cycles), 32'd2);
        checkOutput("rd_no_write", 32'(wr_cycles), 32'd0);
        checkOutput("rd_data", 32'(rdata_at_done), 32'h000F);
        repeat (3) @(negedge clk);
        checkOutput("rd_data_held", 32'(cpu_rdata), 32'h000F);

        // RAMSIZE=16 instance: in-range read, then out-of-range read.
        applyStimulus(1'b1, 1'b0, 8'h03, 16'h0000, 1'b0);
        checkOutput("b_rd_data", 32'(rdata_at_done), 32'hA5A5);
        checkOutput("b_rd_done_at", 32'(done_at), 32'd4);
        applyStimulus(1'b1, 1'b0, 8'h20, 16'h0000, 1'b0);
        checkOutput("oor_done_at", 32'(done_at), 32'd1);
        checkOutput("oor_err", 32'(err_at_done), 32'd1);
        checkOutput("oor_no_read", 32'(rd_cycles), 32'd0);
        checkOutput("oor_no_write", 32'(wr_cycles), 32'd0);
        checkOutput("oor_rdata_kept", 32'(rdata_at_done), 32'hA5A5);
        checkOutput("oor_ram_addr_kept", 32'(addr_log[0]), 32'h03);
        @(negedge clk);
        checkOutput("oor_err_clears", 32'(err_b), 32'd0);

        // Back-to-back with req held: write 0x11 = 0x0004 then read it.
        applyStimulus(1'b0, 1'b1, 8'h11, 16'h0004, 1'b1);
        n = accept_cyc;
        checkOutput("b2b_wr_ready_low", 32'(ready_low), 32'd1);
        applyStimulus(1'b0, 1'b0, 8'h11, 16'h0000, 1'b0);
        checkOutput("b2b_spacing", 32'(accept_cyc - n), 32'(W + 5));
        checkOutput("b2b_rd_data", 32'(rdata_at_done), 32'h0004);
        checkOutput("b2b_rd_ready_low", 32'(ready_low), 32'd1);

        // Reset in the middle of a write strobe.
        repeat (2) @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h30; cpu_wdata = 16'hBEEF;
        @(posedge clk);
        @(negedge clk);
        cpu_req = 1'b0;
        @(posedge clk);
        #2;
        checkOutput("mid_strobe_active", 32'(ram_write), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("async_write_drop", 32'(ram_write), 32'd0);
        checkOutput("async_ready", 32'(cpu_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h30, 16'h0000, 1'b0);
        checkOutput("post_rst_done_at", 32'(done_at), 32'd4);
        checkOutput("post_rst_rdata", 32'(rdata_at_done), 32'hBEEF);
        checkOutput("post_rst_err", 32'(err_at_done), 32'd0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
